mult_fu_ctrl: RTL

- Issue/retire controller that wraps the pipelined 64-bit multiplier (`MULT_STAGES` stages) as the RV32M multiply functional unit.
- Accepts one multiply op per cycle from the reservation station and drives the multiplier's start/mcand/mplier. Signed and unsigned variants are produced by sign- or zero-extending the 32-bit operands to 64 bits.
- Carries each op's tag alongside the pipeline, buffers completed results in an output FIFO, and arbitrates them onto the CDB.
- Credit-based backpressure guarantees the non-stallable multiplier never produces a result with nowhere to store it.

---
 rtl/mult_fu_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mult_fu_ctrl.sv
// RV32M multiply functional unit controller: issues ops into a fixed-latency
// multiplier, tracks tags alongside it, buffers results and offers them to the CDB.
module mult_fu_ctrl #(
  parameter int STAGES  = 4,
  parameter int CREDITS = 5,
  parameter int TAG_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_func,
  input  logic [31:0]      issue_rs1,
  input  logic [31:0]      issue_rs2,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             mult_start,
  output logic [63:0]      mult_mcand,
  output logic [63:0]      mult_mplier,
  input  logic [63:0]      mult_product,
  input  logic             mult_done,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  input  logic             cdb_grant,
  output logic             busy
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam logic [CW-1:0] CRED = CW'(CREDITS);
  localparam logic [PW-1:0] LAST = PW'(CREDITS - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [STAGES-1:0] mv_q, mv_d;
  logic [1:0]       mf_q [STAGES];
  logic [1:0]       mf_d [STAGES];
  logic [TAG_W-1:0] mt_q [STAGES];
  logic [TAG_W-1:0] mt_d [STAGES];
  logic [TAG_W-1:0] ft_q [CREDITS];
  logic [TAG_W-1:0] ft_d [CREDITS];
  logic [31:0]      fv_q [CREDITS];
  logic [31:0]      fv_d [CREDITS];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    occ_q, occ_d;

  logic issue_fire;
  logic rs1_sgn;
  logic rs2_sgn;
  logic push;
  logic pop;
  logic [31:0] res;
  logic unused_done;

  // the multiplier cannot stall, so the credit count alone gates issue
  assign issue_ready = (count_q < CRED);
  assign issue_fire  = issue_valid & issue_ready & ~squash & ~reset;
  assign mult_start  = issue_fire;
  assign busy        = (count_q != '0);
  assign unused_done = mult_done;

  always_comb begin
    rs1_sgn = 1'b0;
    rs2_sgn = 1'b0;
    unique case (1'b1)
      (issue_func == 2'd0),
      (issue_func == 2'd1): begin
        rs1_sgn = 1'b1;
        rs2_sgn = 1'b1;
      end
      (issue_func == 2'd2): rs1_sgn = 1'b1;
      default: ;
    endcase
  end

  assign mult_mcand  = {{32{rs1_sgn & issue_rs1[31]}}, issue_rs1};
  assign mult_mplier = {{32{rs2_sgn & issue_rs2[31]}}, issue_rs2};

  assign push = mv_q[STAGES-1];
  assign res  = (mf_q[STAGES-1] == 2'd0) ? mult_product[31:0]
                                         : mult_product[63:32];

  assign cdb_req   = (occ_q != '0);
  assign pop       = cdb_req & cdb_grant;
  assign cdb_tag   = cdb_req ? ft_q[rd_q] : '0;
  assign cdb_value = cdb_req ? fv_q[rd_q] : '0;

  always_comb begin
    count_d = count_q + CW'(issue_fire) - CW'(pop);
    mv_d    = '0;
    mf_d    = mf_q;
    mt_d    = mt_q;
    mv_d[0] = issue_fire;
    mf_d[0] = issue_func;
    mt_d[0] = issue_tag;
    for (int i = 1; i < STAGES; i++) begin
      mv_d[i] = mv_q[i-1];
      mf_d[i] = mf_q[i-1];
      mt_d[i] = mt_q[i-1];
    end
    ft_d  = ft_q;
    fv_d  = fv_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q + CW'(push) - CW'(pop);
    if (push) begin
      ft_d[wr_q] = mt_q[STAGES-1];
      fv_d[wr_q] = res;
      wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
    // flush drops everything, including done pulses still in the multiplier
    if (squash) begin
      count_d = '0;
      mv_d    = '0;
      rd_d    = '0;
      wr_d    = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mv_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        mf_q[i] <= '0;
        mt_q[i] <= '0;
      end
      for (int i = 0; i < CREDITS; i++) begin
        ft_q[i] <= '0;
        fv_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mv_q    <= mv_d;
      mf_q    <= mf_d;
      mt_q    <= mt_d;
      ft_q    <= ft_d;
      fv_q    <= fv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
    end
  end

endmodule
